// File: rtl/sd_reg_bus_bridge.sv
// ---------------------------------------------------------------------------
// sd_reg_bus_bridge
//
// Host-side bus adapter that sits directly in front of the SD host register
// block. Each handshaked host transaction (valid/ready with byte enables) is
// turned into exactly one req/wnr/address/data_in access on the register
// side. The bridge then waits for reg_ack, realigns any read data into the
// host's byte lanes and returns a single response. Only one access is ever
// in flight, so the register block never sees overlapping requests.
//
// Build option:
//   SD_REG_BRIDGE_TIMEOUT_EN - when defined, an access that has not been
//   acknowledged within TIMEOUT_CYCLES ISSUE cycles is abandoned and answered
//   with rsp_err=1. When undefined, ISSUE waits for reg_ack indefinitely.
//
// Parameters:
//   ADDR_W          register address width
//   TIMEOUT_CYCLES  ISSUE cycles without ack before abort (timeout build only)
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   host_valid      host request valid
//   host_ready      bridge can accept a request
//   host_wnr        1 = write, 0 = read
//   host_addr       byte address; [1:0] ignored, lane comes from host_be
//   host_be         byte enables (0001/0010/0100/1000/0011/1100/1111 legal)
//   host_wdata      write data, lane-aligned
//   rsp_valid       response valid
//   rsp_ready       host accepts response
//   rsp_rdata       read data, lane-aligned, zero outside enabled lanes
//   rsp_err         illegal byte enable (or timeout)
//   reg_wnr         register block write-not-read
//   reg_req         register block access size: 00 idle, 01 byte,
//                   10 16-bit, 11 32-bit
//   reg_address     register block address
//   reg_data_in     register block write data, right-justified
//   reg_ack         register block acknowledge
//   reg_data_out    register block read data, right-justified, valid with ack
// ---------------------------------------------------------------------------
module sd_reg_bus_bridge #(
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic              host_wnr,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [3:0]        host_be,
   input  logic [31:0]       host_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              reg_wnr,
   output logic [1:0]        reg_req,
   output logic [ADDR_W-1:0] reg_address,
   output logic [31:0]       reg_data_in,
   input  logic              reg_ack,
   input  logic [31:0]       reg_data_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              host_ready_q, host_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              reg_wnr_q, reg_wnr_d;
   logic [1:0]        reg_req_q, reg_req_d;
   logic [ADDR_W-1:0] reg_address_q, reg_address_d;
   logic [31:0]       reg_data_in_q, reg_data_in_d;
   // Byte enables and lowest lane of the accepted request, kept so the
   // read data can be put back into the lanes the host asked for.
   logic [3:0]        be_q, be_d;
   logic [1:0]        lane_q, lane_d;

   logic              dec_legal;
   logic [1:0]        dec_req;
   logic [1:0]        dec_lane;
   logic [31:0]       dec_data;
   logic [31:0]       be_mask;
   logic [31:0]       rd_aligned;

`ifdef SD_REG_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic              unused_bits;
   assign unused_bits = ^host_addr[1:0];
`else
   logic              unused_bits;
   assign unused_bits = ^{host_addr[1:0], 32'(TIMEOUT_CYCLES)};
`endif

   // Byte-enable decode: access size, lowest lane and the right-justified
   // write data for that lane. Anything not listed is rejected outright.
   always_comb begin
      dec_legal = 1'b0;
      dec_req   = 2'b00;
      dec_lane  = 2'd0;
      dec_data  = 32'h0;
      case (host_be)
         4'b0001: begin
            dec_legal = 1'b1;
            dec_req   = 2'b01;
            dec_lane  = 2'd0;
            dec_data  = {24'h0, host_wdata[7:0]};
         end
         4'b0010: begin
            dec_legal = 1'b1;
            dec_req   = 2'b01;
            dec_lane  = 2'd1;
            dec_data  = {24'h0, host_wdata[15:8]};
         end
         4'b0100: begin
            dec_legal = 1'b1;
            dec_req   = 2'b01;
            dec_lane  = 2'd2;
            dec_data  = {24'h0, host_wdata[23:16]};
         end
         4'b1000: begin
            dec_legal = 1'b1;
            dec_req   = 2'b01;
            dec_lane  = 2'd3;
            dec_data  = {24'h0, host_wdata[31:24]};
         end
         4'b0011: begin
            dec_legal = 1'b1;
            dec_req   = 2'b10;
            dec_lane  = 2'd0;
            dec_data  = {16'h0, host_wdata[15:0]};
         end
         4'b1100: begin
            dec_legal = 1'b1;
            dec_req   = 2'b10;
            dec_lane  = 2'd2;
            dec_data  = {16'h0, host_wdata[31:16]};
         end
         4'b1111: begin
            dec_legal = 1'b1;
            dec_req   = 2'b11;
            dec_lane  = 2'd0;
            dec_data  = host_wdata;
         end
         default: begin
            dec_legal = 1'b0;
         end
      endcase
   end

   // Shifting by the lowest lane and masking with the enables both moves the
   // data into place and clears whatever the register block returned above
   // the access width.
   assign be_mask    = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
   assign rd_aligned = (reg_data_out << {lane_q, 3'b000}) & be_mask;

   always_comb begin
      state_d       = state_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      reg_wnr_d     = reg_wnr_q;
      reg_req_d     = reg_req_q;
      reg_address_d = reg_address_q;
      reg_data_in_d = reg_data_in_q;
      be_d          = be_q;
      lane_d        = lane_q;
`ifdef SD_REG_BRIDGE_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (host_valid && host_ready_q) begin
               be_d   = host_be;
               lane_d = dec_lane;
               if (dec_legal) begin
                  reg_req_d     = dec_req;
                  reg_wnr_d     = host_wnr;
                  reg_address_d = {host_addr[ADDR_W-1:2], dec_lane};
                  reg_data_in_d = dec_data;
                  state_d       = ISSUE;
`ifdef SD_REG_BRIDGE_TIMEOUT_EN
                  tmo_cnt_d     = '0;
`endif
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
                  state_d     = RESP;
               end
            end
         end

         ISSUE: begin
            // Ack is checked first so that an ack arriving on the expiry
            // cycle still completes normally.
            if (reg_ack) begin
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b0;
               rsp_rdata_d   = reg_wnr_q ? 32'h0 : rd_aligned;
               reg_req_d     = 2'b00;
               reg_wnr_d     = 1'b0;
               reg_address_d = '0;
               reg_data_in_d = 32'h0;
               state_d       = RESP;
            end
`ifdef SD_REG_BRIDGE_TIMEOUT_EN
            else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_rdata_d   = 32'h0;
               reg_req_d     = 2'b00;
               reg_wnr_d     = 1'b0;
               reg_address_d = '0;
               reg_data_in_d = 32'h0;
               state_d       = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = 32'h0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered ready means the cycle of a response handshake can never
      // also accept a new request; ready reappears one cycle later.
      host_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         host_ready_q  <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= 32'h0;
         rsp_err_q     <= 1'b0;
         reg_wnr_q     <= 1'b0;
         reg_req_q     <= 2'b00;
         reg_address_q <= '0;
         reg_data_in_q <= 32'h0;
         be_q          <= 4'h0;
         lane_q        <= 2'd0;
`ifdef SD_REG_BRIDGE_TIMEOUT_EN
         tmo_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         host_ready_q  <= host_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         reg_wnr_q     <= reg_wnr_d;
         reg_req_q     <= reg_req_d;
         reg_address_q <= reg_address_d;
         reg_data_in_q <= reg_data_in_d;
         be_q          <= be_d;
         lane_q        <= lane_d;
`ifdef SD_REG_BRIDGE_TIMEOUT_EN
         tmo_cnt_q     <= tmo_cnt_d;
`endif
      end
   end

   assign host_ready  = host_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign reg_wnr     = reg_wnr_q;
   assign reg_req     = reg_req_q;
   assign reg_address = reg_address_q;
   assign reg_data_in = reg_data_in_q;

endmodule

// File: tb/tb_sd_reg_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_sd_reg_bus_bridge
//
// Drives host transactions and plays the register block. For each request a
// transaction-level model works out the access the register block must see
// and the response the host must get; a negedge process compares every
// output against those expectations each cycle.
// ---------------------------------------------------------------------------
module tb_sd_reg_bus_bridge;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              host_valid = 1'b0;
   logic              host_ready;
   logic              host_wnr = 1'b0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic [3:0]        host_be = 4'h0;
   logic [31:0]       host_wdata = 32'h0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              reg_wnr;
   logic [1:0]        reg_req;
   logic [ADDR_W-1:0] reg_address;
   logic [31:0]       reg_data_in;
   logic              reg_ack = 1'b0;
   logic [31:0]       reg_data_out = 32'h0;

   int total = 0;
   int bad   = 0;

   logic              chk_en        = 1'b0;
   logic              chk_all_zero  = 1'b0;
   logic              chk_ready     = 1'b0;
   logic              exp_ready     = 1'b0;
   logic [1:0]        exp_req       = 2'b00;
   logic [ADDR_W-1:0] exp_addr      = '0;
   logic [31:0]       exp_din       = 32'h0;
   logic              exp_wnr       = 1'b0;
   logic              exp_rsp_valid = 1'b0;
   logic [31:0]       exp_rdata     = 32'h0;
   logic              exp_err       = 1'b0;

   sd_reg_bus_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(255)) dut (
      .clk          (clk),
      .reset        (reset),
      .host_valid   (host_valid),
      .host_ready   (host_ready),
      .host_wnr     (host_wnr),
      .host_addr    (host_addr),
      .host_be      (host_be),
      .host_wdata   (host_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .reg_wnr      (reg_wnr),
      .reg_req      (reg_req),
      .reg_address  (reg_address),
      .reg_data_in  (reg_data_in),
      .reg_ack      (reg_ack),
      .reg_data_out (reg_data_out)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, required, $time);
      end
   endtask

   // Per-cycle comparison against the current expectations
   always @(negedge clk) begin
      if (chk_en) begin
         if (chk_ready)
            checkOutput("host_ready", 32'(host_ready), 32'(exp_ready));
         checkOutput("reg_req", 32'(reg_req), 32'(exp_req));
         if (exp_req != 2'b00) begin
            checkOutput("reg_address", 32'(reg_address), 32'(exp_addr));
            checkOutput("reg_data_in", reg_data_in, exp_din);
            checkOutput("reg_wnr", 32'(reg_wnr), 32'(exp_wnr));
         end
         checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
         if (exp_rsp_valid) begin
            checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
            checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
         end
         if (chk_all_zero) begin
            checkOutput("rst_host_ready", 32'(host_ready), 32'd0);
            checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
            checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
            checkOutput("rst_reg_wnr", 32'(reg_wnr), 32'd0);
            checkOutput("rst_reg_address", 32'(reg_address), 32'd0);
            checkOutput("rst_reg_data_in", reg_data_in, 32'd0);
         end
      end
   end

   // Transaction-level model of the byte-enable rules
   function automatic void model_decode(input logic [3:0] be, input logic [7:0] addr,
                                        input logic [31:0] wdata, output logic legal,
                                        output logic [1:0] req, output logic [7:0] a,
                                        output logic [31:0] din);
      int low;
      int nbytes;
      logic [31:0] width_mask;
      low    = 0;
      nbytes = $countones(be);
      for (int i = 3; i >= 0; i--)
         if (be[i]) low = i;
      legal = (nbytes == 1) || (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
      case (nbytes)
         1:       begin req = 2'b01; width_mask = 32'h0000_00FF; end
         2:       begin req = 2'b10; width_mask = 32'h0000_FFFF; end
         4:       begin req = 2'b11; width_mask = 32'hFFFF_FFFF; end
         default: begin req = 2'b00; width_mask = 32'h0; end
      endcase
      if (!legal) req = 2'b00;
      a   = 8'((addr & 8'hFC) + 8'(low));
      din = (wdata >> (8 * low)) & width_mask;
   endfunction

   function automatic logic [31:0] model_align(input logic [3:0] be, input logic [31:0] data);
      int low;
      logic [31:0] mask;
      low  = 0;
      mask = 32'h0;
      for (int i = 3; i >= 0; i--) begin
         if (be[i]) begin
            low  = i;
            mask = mask | (32'hFF << (8 * i));
         end
      end
      return (data << (8 * low)) & mask;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_junk();
      host_valid = 1'($urandom_range(0, 1));
      host_wnr   = 1'($urandom_range(0, 1));
      host_addr  = 8'($urandom);
      host_be    = 4'($urandom);
      host_wdata = $urandom;
   endtask

   task automatic expect_idle();
      exp_ready     = 1'b1;
      exp_req       = 2'b00;
      exp_rsp_valid = 1'b0;
   endtask

   task automatic reset_and_recover(input int cycles);
      reset      = 1'b1;
      host_valid = 1'b0;
      rsp_ready  = 1'b0;
      reg_ack    = 1'b0;
      step();
      chk_en        = 1'b1;
      chk_all_zero  = 1'b1;
      chk_ready     = 1'b1;
      exp_ready     = 1'b0;
      exp_req       = 2'b00;
      exp_rsp_valid = 1'b0;
      repeat (cycles - 1) step();
      reset     = 1'b0;
      chk_ready = 1'b0;
      step();
      chk_all_zero = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (host_ready) break;
         step();
      end
      checkOutput("ready_after_reset", 32'(host_ready), 32'd1);
      exp_ready = 1'b1;
      chk_ready = 1'b1;
   endtask

   // mode: 0 normal, 1 reset during the last ISSUE cycle, 2 reset in RESP
   task automatic applyStimulus(input logic wnr, input logic [7:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input int ack_delay,
                                input logic [31:0] reg_data, input int rsp_delay, input int mode,
                                input int idle_before, input logic pin_en,
                                input logic [7:0] pin_addr, input logic [31:0] pin_rdata);
      logic        legal;
      logic [1:0]  m_req;
      logic [7:0]  m_addr;
      logic [31:0] m_din;
      logic [31:0] m_rdata;
      model_decode(be, addr, wdata, legal, m_req, m_addr, m_din);
      m_rdata = (legal && !wnr) ? model_align(be, reg_data) : 32'h0;

      repeat (idle_before) begin
         host_valid   = 1'b0;
         reg_ack      = 1'($urandom_range(0, 1));
         reg_data_out = $urandom;
         expect_idle();
         step();
      end

      host_valid   = 1'b1;
      host_wnr     = wnr;
      host_addr    = addr;
      host_be      = be;
      host_wdata   = wdata;
      reg_ack      = 1'($urandom_range(0, 1));
      reg_data_out = $urandom;
      expect_idle();
      step();

      if (legal) begin
         for (int i = 0; i <= ack_delay; i++) begin
            drive_junk();
            exp_ready     = 1'b0;
            exp_req       = m_req;
            exp_addr      = m_addr;
            exp_din       = m_din;
            exp_wnr       = wnr;
            exp_rsp_valid = 1'b0;
            if (pin_en && i == 0)
               checkOutput("pin_reg_address", 32'(reg_address), 32'(pin_addr));
            if (mode == 1 && i == ack_delay) begin
               reset_and_recover(1);
               return;
            end
            reg_ack      = (i == ack_delay);
            reg_data_out = (i == ack_delay) ? reg_data : $urandom;
            step();
         end
      end

      for (int j = 0; j <= rsp_delay; j++) begin
         drive_junk();
         exp_ready     = 1'b0;
         exp_req       = 2'b00;
         exp_rsp_valid = 1'b1;
         exp_rdata     = m_rdata;
         exp_err       = !legal;
         reg_ack       = 1'($urandom_range(0, 1));
         reg_data_out  = $urandom;
         if (pin_en && j == 0)
            checkOutput("pin_rsp_rdata", rsp_rdata, pin_rdata);
         if (mode == 2 && j == rsp_delay) begin
            reset_and_recover(1);
            return;
         end
         rsp_ready = (j == rsp_delay);
         step();
      end
      rsp_ready  = 1'b0;
      host_valid = 1'b0;
      reg_ack    = 1'b0;
      expect_idle();
   endtask

   initial begin
      logic [3:0] legal_be [7];
      logic [3:0] be;
      int         mode;
      legal_be = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

      $display("[TB] start");
      reset_and_recover(3);

      // 32-bit write
      applyStimulus(1'b1, 8'h28, 4'b1111, 32'h0000_0F0F, 2, 32'hDEAD_BEEF, 0, 0, 0,
                    1'b1, 8'h28, 32'h0);
      // byte read from lane 2
      applyStimulus(1'b0, 8'h2C, 4'b0100, 32'h0, 0, 32'h0000_00A5, 0, 0, 0,
                    1'b1, 8'h2E, 32'h00A5_0000);
      // upper halfword read, slow ack
      applyStimulus(1'b0, 8'h04, 4'b1100, 32'h0, 5, 32'h0000_1234, 1, 0, 1,
                    1'b1, 8'h06, 32'h1234_0000);
      // illegal enables
      applyStimulus(1'b0, 8'h10, 4'b0101, 32'h0, 0, 32'h0, 0, 0, 0,
                    1'b1, 8'h00, 32'h0);
      applyStimulus(1'b1, 8'h10, 4'b0000, 32'h1234_5678, 0, 32'h0, 2, 0, 0,
                    1'b1, 8'h00, 32'h0);
      // held-off response
      applyStimulus(1'b0, 8'h41, 4'b1000, 32'h0, 1, 32'hFFFF_FF3C, 4, 0, 0,
                    1'b1, 8'h43, 32'h3C00_0000);
      // reset while in ISSUE, then while in RESP
      applyStimulus(1'b0, 8'h20, 4'b0011, 32'h0, 3, 32'h5555_AAAA, 0, 1, 0,
                    1'b0, 8'h00, 32'h0);
      applyStimulus(1'b1, 8'h30, 4'b0010, 32'hCAFE_F00D, 1, 32'h0, 2, 2, 0,
                    1'b0, 8'h00, 32'h0);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) < 7)
            be = legal_be[$urandom_range(0, 6)];
         else
            be = 4'($urandom);
         mode = ($urandom_range(0, 49) == 0) ? int'($urandom_range(1, 2)) : 0;
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), be, $urandom,
                       int'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 3)),
                       mode, int'($urandom_range(0, 2)), 1'b0, 8'h00, 32'h0);
      end

      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
